// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the half-period of a slow square wave
// in clk cycles, with lock and loss-of-signal reporting.
module clk_period_meter #(
    parameter int W   = 16,
    parameter int TOL = 1
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         sig_in,
    output logic [W-1:0] half_period,
    output logic [W-1:0] n_est,
    output logic         valid,
    output logic         locked,
    output logic         timeout
);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        OVERFLOW
    } state_t;

    localparam logic [W-1:0] CMAX = '1;
    localparam logic [W-1:0] TOLW = W'(TOL);

    state_t         state;
    logic           s1;
    logic           s2;
    logic           s3;
    logic           sig_edge;
    logic [W-1:0]   cnt;
    logic [W-1:0]   diff;
    logic           in_tol;
    logic           have_prev;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sig_edge = s2 ^ s3;

    // Cycles since the last edge; restarts at 1 and saturates at all-ones.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt <= '0;
        end else if (sig_edge) begin
            cnt <= W'(1);
        end else if (cnt != CMAX) begin
            cnt <= cnt + W'(1);
        end
    end

    assign diff   = (cnt >= half_period) ? cnt - half_period
                                         : half_period - cnt;
    assign in_tol = (diff <= TOLW);

    assign n_est  = (half_period == '0) ? '0 : half_period - W'(1);

    // Measurement FSM: discards the first edge, captures later ones,
    // and flags loss of signal when the counter saturates.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            half_period <= '0;
            valid       <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
            have_prev   <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sig_edge) begin
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (sig_edge) begin
                        half_period <= cnt;
                        valid       <= 1'b1;
                        locked      <= have_prev && in_tol;
                        have_prev   <= 1'b1;
                    end else if (cnt == CMAX) begin
                        state     <= OVERFLOW;
                        timeout   <= 1'b1;
                        locked    <= 1'b0;
                        have_prev <= 1'b0;
                    end
                end
                OVERFLOW: begin
                    if (sig_edge) begin
                        state   <= MEASURE;
                        timeout <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: table-driven and scoreboard bench for
// clk_period_meter (W=4/TOL=1 main instance, W=16/TOL=0 second).
module tb_clk_period_meter;

    typedef struct {
        int         gap;
        bit         pv;
        logic [3:0] hp;
        bit         lk;
        bit         lk0;
    } vec_t;

    typedef struct {
        logic [3:0] hp;
        bit         lk;
        bit         chk0;
        bit         lk0;
    } exp_t;

    logic        clk;
    logic        n_reset;
    logic        sig_in;
    logic [3:0]  hp;
    logic [3:0]  ne;
    logic        vld;
    logic        lck;
    logic        to;
    logic [15:0] hp0;
    logic [15:0] ne0;
    logic        vld0;
    logic        lck0;
    logic        to0;

    int   total;
    int   bad;
    bit   watch_to;
    int   to_seen;
    exp_t q[$];
    vec_t tbl[12];

    clk_period_meter #(.W(4), .TOL(1)) dut (
        .clk(clk), .n_reset(n_reset), .sig_in(sig_in),
        .half_period(hp), .n_est(ne), .valid(vld),
        .locked(lck), .timeout(to)
    );

    clk_period_meter #(.W(16), .TOL(0)) dut0 (
        .clk(clk), .n_reset(n_reset), .sig_in(sig_in),
        .half_period(hp0), .n_est(ne0), .valid(vld0),
        .locked(lck0), .timeout(to0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tog(int gap, bit pv, logic [3:0] h,
                       bit lk, bit c0, bit lk0);
        exp_t e;
        tick(gap);
        sig_in = ~sig_in;
        if (pv) begin
            e.hp   = h;
            e.lk   = lk;
            e.chk0 = c0;
            e.lk0  = lk0;
            q.push_back(e);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (n_reset && vld) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got hp=%0d want none", hp);
            end else begin
                e = q.pop_front();
                check("half_period", 32'(hp), 32'(e.hp));
                check("n_est", 32'(ne), 32'(e.hp - 4'd1));
                check("locked", 32'(lck), 32'(e.lk));
                if (e.chk0) begin
                    check("valid0", 32'(vld0), 32'd1);
                    check("half_period0", 32'(hp0), 32'(e.hp));
                    check("locked0", 32'(lck0), 32'(e.lk0));
                end
            end
        end
        if (watch_to && to) to_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        total    = 0;
        bad      = 0;
        watch_to = 0;
        to_seen  = 0;

        tbl[0]  = '{3, 0, 4'd0, 0, 0};
        tbl[1]  = '{5, 1, 4'd5, 0, 0};
        tbl[2]  = '{5, 1, 4'd5, 1, 1};
        tbl[3]  = '{5, 1, 4'd5, 1, 1};
        tbl[4]  = '{5, 1, 4'd5, 1, 1};
        tbl[5]  = '{9, 1, 4'd9, 0, 0};
        tbl[6]  = '{9, 1, 4'd9, 1, 1};
        tbl[7]  = '{7, 1, 4'd7, 0, 0};
        tbl[8]  = '{8, 1, 4'd8, 1, 0};
        tbl[9]  = '{7, 1, 4'd7, 1, 0};
        tbl[10] = '{8, 1, 4'd8, 1, 0};
        tbl[11] = '{7, 1, 4'd7, 1, 0};

        n_reset = 1'b0;
        sig_in  = 1'b0;
        tick(3);
        check("rst_hp", 32'(hp), 32'd0);
        check("rst_nest", 32'(ne), 32'd0);
        check("rst_valid", 32'(vld), 32'd0);
        check("rst_locked", 32'(lck), 32'd0);
        check("rst_timeout", 32'(to), 32'd0);
        n_reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            tog(tbl[i].gap, tbl[i].pv, tbl[i].hp,
                tbl[i].lk, 1'b1, tbl[i].lk0);
        end

        repeat (17) @(posedge clk);
        @(negedge clk);
        check("timeout_early", 32'(to), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("timeout_set", 32'(to), 32'd1);
        check("timeout_unlock", 32'(lck), 32'd0);

        tick(3);
        sig_in = ~sig_in;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("timeout_hold", 32'(to), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("timeout_clear", 32'(to), 32'd0);
        tog(3, 1, 4'd6, 0, 0, 0);
        tog(6, 1, 4'd6, 1, 0, 0);

        watch_to = 1;
        tog(15, 1, 4'd15, 0, 0, 0);
        tog(15, 1, 4'd15, 1, 0, 0);
        tog(15, 1, 4'd15, 1, 0, 0);
        tog(4, 1, 4'd4, 0, 0, 0);
        tick(5);
        watch_to = 0;
        check("boundary_no_timeout", 32'(to_seen), 32'd0);

        sig_in = ~sig_in;
        tick(1);
        n_reset = 1'b0;
        #1;
        check("mrst_hp", 32'(hp), 32'd0);
        check("mrst_nest", 32'(ne), 32'd0);
        check("mrst_locked", 32'(lck), 32'd0);
        check("mrst_timeout", 32'(to), 32'd0);
        check("mrst_hp0", 32'(hp0), 32'd0);
        check("mrst_queue", 32'(q.size()), 32'd0);
        sig_in = 1'b1;
        tick(3);
        n_reset = 1'b1;
        tog(7, 1, 4'd7, 0, 1, 0);
        tog(7, 1, 4'd7, 1, 1, 1);

        tick(6);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
